// File: rtl/board_rle_encoder_if.sv
// Cell-stream input and encoded-byte output handshakes of the board RLE encoder.
// master = surrounding video/HPS logic, slave = the encoder.
interface board_rle_encoder_if;
  logic       pix_valid;
  logic       pix_data;
  logic       pix_sof;
  logic       pix_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;

  modport master (
    output pix_valid, pix_data, pix_sof, out_ready,
    input  pix_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  pix_valid, pix_data, pix_sof, out_ready,
    output pix_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/board_rle_encoder.sv
// Packs one frame of Game of Life cells into loader-format run-length bytes:
// bit 7 = cell value, bits 6:0 = run length - 1.
module board_rle_encoder #(
  parameter int unsigned FRAME_PIXELS = 2073600,
  parameter int unsigned CNT_W        = 22
) (
  input  logic                    HDMI_CLK,
  input  logic                    RESET,
  input  logic                    start,
  board_rle_encoder_if.slave      bus,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        byte_count
);

  localparam logic [CNT_W-1:0] LAST_CELL = CNT_W'(FRAME_PIXELS - 1);

  typedef enum logic [2:0] {StIdle, StWaitSof, StRun, StFlush, StDone} state_e;

  state_e           state_q;
  logic             run_val_q;
  logic [6:0]       run_cnt_q;
  logic [CNT_W-1:0] cell_cnt_q;
  logic             out_valid_q;
  logic [7:0]       out_data_q;
  logic             out_last_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] byte_count_q;

  logic pix_ready;
  logic pix_xfer;
  logic out_xfer;

  // Only RUN is throttled by the single-entry output register; FLUSH takes no cells.
  always_comb begin
    pix_ready = 1'b1;
    case (state_q)
      StRun:   pix_ready = ~out_valid_q | bus.out_ready;
      StFlush: pix_ready = 1'b0;
      default: pix_ready = 1'b1;
    endcase
  end

  assign pix_xfer = bus.pix_valid & pix_ready;
  assign out_xfer = out_valid_q & bus.out_ready;

  always_ff @(posedge HDMI_CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= StIdle;
      run_val_q    <= 1'b0;
      run_cnt_q    <= 7'd0;
      cell_cnt_q   <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 8'd0;
      out_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      byte_count_q <= '0;
    end else begin
      if (out_xfer) begin
        out_valid_q  <= 1'b0;
        out_last_q   <= 1'b0;
        byte_count_q <= byte_count_q + CNT_W'(1);
      end

      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q      <= StWaitSof;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            byte_count_q <= '0;
            cell_cnt_q   <= '0;
            run_val_q    <= 1'b0;
            run_cnt_q    <= 7'd0;
          end
        end

        StWaitSof: begin
          if (pix_xfer && bus.pix_sof) begin
            run_val_q  <= bus.pix_data;
            run_cnt_q  <= 7'd0;
            cell_cnt_q <= CNT_W'(1);
            state_q    <= (FRAME_PIXELS == 1) ? StFlush : StRun;
          end
        end

        StRun: begin
          if (pix_xfer) begin
            cell_cnt_q <= cell_cnt_q + CNT_W'(1);
            if (bus.pix_data == run_val_q && run_cnt_q != 7'd127) begin
              run_cnt_q <= run_cnt_q + 7'd1;
            end else begin
              // Overrides the drain above when the previous byte leaves this same cycle.
              out_valid_q <= 1'b1;
              out_data_q  <= {run_val_q, run_cnt_q};
              out_last_q  <= 1'b0;
              run_val_q   <= bus.pix_data;
              run_cnt_q   <= 7'd0;
            end
            if (cell_cnt_q == LAST_CELL) state_q <= StFlush;
          end
        end

        StFlush: begin
          if (out_valid_q && out_last_q) begin
            if (bus.out_ready) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else if (!out_valid_q || bus.out_ready) begin
            out_valid_q <= 1'b1;
            out_data_q  <= {run_val_q, run_cnt_q};
            out_last_q  <= 1'b1;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.pix_ready = pix_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign byte_count    = byte_count_q;

endmodule

// File: tb/tb_board_rle_encoder.sv
// Scoreboard bench for board_rle_encoder with a 130-cell board.
module tb_board_rle_encoder;
  localparam int unsigned FP    = 130;
  localparam int unsigned CNT_W = 22;

  logic             HDMI_CLK;
  logic             RESET;
  logic             start;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] byte_count;

  board_rle_encoder_if bus ();

  board_rle_encoder #(
    .FRAME_PIXELS (FP),
    .CNT_W        (CNT_W)
  ) dut (
    .HDMI_CLK   (HDMI_CLK),
    .RESET      (RESET),
    .start      (start),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .byte_count (byte_count)
  );

  initial HDMI_CLK = 1'b0;
  always #5 HDMI_CLK = ~HDMI_CLK;

  int         vectors     = 0;
  int         miscompares = 0;
  int         stall_cnt   = 0;
  logic [8:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every output transfer pops one expected {last, byte}.
  always @(negedge HDMI_CLK) begin
    logic [8:0] e;
    if (!RESET && bus.out_valid && bus.out_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL out_byte: got %03h with nothing expected", {bus.out_last, bus.out_data});
      end else begin
        e = exp_q.pop_front();
        if ({bus.out_last, bus.out_data} !== e) begin
          miscompares++;
          $display("FAIL out_byte: got %03h expected %03h", {bus.out_last, bus.out_data}, e);
        end
      end
    end
  end

  task automatic send_cell(input logic v, input logic sof);
    logic acc;
    int   g;
    bus.pix_valid = 1'b1;
    bus.pix_data  = v;
    bus.pix_sof   = sof;
    g = 0;
    do begin
      @(negedge HDMI_CLK);
      acc = bus.pix_ready;
      if (!acc) stall_cnt++;
      @(posedge HDMI_CLK);
      #1;
      g++;
    end while (!acc && g < 200);
    if (!acc) check("cell_accept_timeout", 32'(acc), 32'd1);
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
  endtask

  task automatic send_seg(input logic v, input int n, input logic sof_first);
    for (int i = 0; i < n; i++) send_cell(v, sof_first && (i == 0));
  endtask

  task automatic do_start();
    @(posedge HDMI_CLK);
    #1 start = 1'b1;
    @(posedge HDMI_CLK);
    #1 start = 1'b0;
  endtask

  task automatic finish_frame(input string name, input int bytes);
    int g;
    g = 0;
    while (!done && g < 400) begin
      @(negedge HDMI_CLK);
      g++;
    end
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_byte_count"}, 32'(byte_count), 32'(bytes));
    check({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic stall_once();
    logic [7:0] held;
    int         g;
    g = 0;
    while (byte_count < 2 && g < 400) begin
      @(negedge HDMI_CLK);
      g++;
    end
    @(posedge HDMI_CLK);
    #1 bus.out_ready = 1'b0;
    g = 0;
    do begin
      @(negedge HDMI_CLK);
      g++;
    end while (!bus.out_valid && g < 400);
    check("stall_pending", 32'(bus.out_valid), 32'd1);
    held = bus.out_data;
    for (int i = 0; i < 5; i++) begin
      check("stall_pix_ready", 32'(bus.pix_ready), 32'd0);
      check("stall_out_data", 32'(bus.out_data), 32'(held));
      @(negedge HDMI_CLK);
    end
    @(posedge HDMI_CLK);
    #1 bus.out_ready = 1'b1;
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_pix_ready"}, 32'(bus.pix_ready), 32'd1);
    check({name, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({name, "_out_data"}, 32'(bus.out_data), 32'd0);
    check({name, "_out_last"}, 32'(bus.out_last), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_byte_count"}, 32'(byte_count), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    RESET         = 1'b1;
    start         = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_data  = 1'b0;
    bus.pix_sof   = 1'b0;
    bus.out_ready = 1'b1;
    #3;
    check_reset_values("por");
    repeat (2) @(negedge HDMI_CLK);
    RESET = 1'b0;

    // 130 ones: run wraps at 128 -> 0xFF, then a 2-cell run 0x81 (last).
    do_start();
    check("a_busy", 32'(busy), 32'd1);
    exp_q.push_back(9'h0FF);
    exp_q.push_back(9'h181);
    stall_cnt = 0;
    send_seg(1'b1, 130, 1'b1);
    check("a_no_stall", 32'(stall_cnt), 32'd0);
    finish_frame("a", 2);

    // Pre-sof cells ignored; 1,1 then 128 zeros -> 0x81, 0x7F (last).
    do_start();
    check("b_done_cleared", 32'(done), 32'd0);
    send_cell(1'b1, 1'b0);
    send_cell(1'b0, 1'b0);
    send_cell(1'b1, 1'b0);
    exp_q.push_back(9'h081);
    exp_q.push_back(9'h17F);
    send_seg(1'b1, 2, 1'b1);
    send_seg(1'b0, 128, 1'b0);
    finish_frame("b", 2);

    // 1,0,1,0 then 126 ones, with a 5-cycle output stall along the way.
    do_start();
    exp_q.push_back(9'h080);
    exp_q.push_back(9'h000);
    exp_q.push_back(9'h080);
    exp_q.push_back(9'h000);
    exp_q.push_back(9'h1FD);
    fork
      begin
        send_cell(1'b1, 1'b1);
        send_cell(1'b0, 1'b0);
        send_cell(1'b1, 1'b0);
        send_cell(1'b0, 1'b0);
        send_seg(1'b1, 126, 1'b0);
      end
      stall_once();
    join
    finish_frame("c", 5);

    // Abort mid-run with a byte (20 zeros -> 0x13) held in the output register.
    do_start();
    bus.out_ready = 1'b0;
    send_seg(1'b0, 20, 1'b1);
    send_cell(1'b1, 1'b0);
    @(negedge HDMI_CLK);
    check("d_pending_valid", 32'(bus.out_valid), 32'd1);
    check("d_pending_data", 32'(bus.out_data), 32'h13);
    check("d_pending_stall", 32'(bus.pix_ready), 32'd0);
    #2 RESET = 1'b1;
    #1;
    check_reset_values("mid_reset");
    @(negedge HDMI_CLK);
    RESET         = 1'b0;
    bus.out_ready = 1'b1;

    // Clean frame after the abort: 16 zeros + 114 ones -> 0x0F, 0xF1 (last).
    do_start();
    exp_q.push_back(9'h00F);
    exp_q.push_back(9'h1F1);
    send_seg(1'b0, 16, 1'b1);
    send_seg(1'b1, 114, 1'b0);
    finish_frame("e", 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
